// File: rtl/sa_ram_pkg.sv
// Shared definitions for the SA RAM model library: address-width helper,
// byte width and the clear-sequencer state encoding.
package sa_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_clr_state_t;

    // A single-word RAM still needs a one-bit address port, so clamp at 1.
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sa_ram_bytemerge.sv
// Combinational byte merge: every byte whose mask bit is set is taken from
// the new word, every other byte is kept from the old word.
module sa_ram_bytemerge
    import sa_ram_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]        oldWord_i,
    input  logic [DW-1:0]        newWord_i,
    input  logic [DW/BYTE_W-1:0] mask_i,
    output logic [DW-1:0]        merged_o
);

    // Start from the old word and overwrite the selected byte lanes.
    always_comb begin
        merged_o = oldWord_i;
        for (int i = 0; i < DW / BYTE_W; i++) begin
            if (mask_i[i]) begin
                merged_o[i*BYTE_W +: BYTE_W] = newWord_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/sa_ram_rwsp_gen.sv
// Parametrised one-read/one-write synchronous RAM with registered read
// address, registered output, byte-masked writes, optional write-to-read
// forwarding and a post-reset clear sequencer that fills every word.
module sa_ram_rwsp_gen
    import sa_ram_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            DEPTH    = 32,
    parameter int            AW       = addrWidth(DEPTH),
    parameter bit            BYPASS   = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        ra,
    input  logic                 re,
    input  logic                 ore,
    output logic [DW-1:0]        dout,
    output logic                 dout_vld,
    input  logic [AW-1:0]        wa,
    input  logic                 we,
    input  logic [DW/BYTE_W-1:0] wmask,
    input  logic [DW-1:0]        di,
    output logic                 init_done,
    output logic                 addr_err,
    input  logic [31:0]          pwrbus_ram_pd
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    ram_clr_state_t state_q, state_d;
    logic [AW-1:0]  clrCnt_q, clrCnt_d;

    logic [AW-1:0]  ra_q;
    logic           raVld_q;
    logic [DW-1:0]  dout_q;
    logic           doutVld_q;
    logic           addrErr_q;

    logic           raInRange;
    logic           waInRange;
    logic           isReady;
    logic           fwdHit;
    logic [DW-1:0]  wrOld;
    logic [DW-1:0]  wrMerged;
    logic [DW-1:0]  rdOld;
    logic [DW-1:0]  fwdMerged;
    logic [DW-1:0]  rdWord;

    // The power-down bus has no effect on this behavioural model.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign raInRange = ({1'b0, ra} < DEPTH_W);
    assign waInRange = ({1'b0, wa} < DEPTH_W);
    assign isReady   = (state_q == READY);

    // Array reads are only meaningful when the address is in range; the
    // callers gate on waInRange / raVld_q before using these words.
    assign wrOld = mem[wa];
    assign rdOld = mem[ra_q];

    sa_ram_bytemerge #(
        .DW(DW)
    ) u_wrMerge (
        .oldWord_i(wrOld),
        .newWord_i(di),
        .mask_i   (wmask),
        .merged_o (wrMerged)
    );

    sa_ram_bytemerge #(
        .DW(DW)
    ) u_fwdMerge (
        .oldWord_i(rdOld),
        .newWord_i(di),
        .mask_i   (wmask),
        .merged_o (fwdMerged)
    );

    // A same-cycle write to the address being captured is forwarded only
    // when BYPASS is set; otherwise the pre-write array word is returned.
    assign fwdHit = BYPASS && we && raVld_q && (wa == ra_q);
    assign rdWord = fwdHit ? fwdMerged : rdOld;

    // Clear-sequencer state register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    // Walk one address per cycle through the array, then park in READY.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        case (state_q)
            CLEAR: begin
                clrCnt_d = clrCnt_q + AW'(1);
                if (clrCnt_q == LAST_ADDR) begin
                    state_d  = READY;
                    clrCnt_d = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d  = CLEAR;
                clrCnt_d = '0;
            end
        endcase
    end

    // Array write port: clear words while sequencing, user writes once ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clrCnt_q] <= INIT_VAL;
            end else if (we && waInRange) begin
                mem[wa] <= wrMerged;
            end
        end
    end

    // Read-address register, output register and sticky address-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q      <= '0;
            raVld_q   <= 1'b0;
            dout_q    <= '0;
            doutVld_q <= 1'b0;
            addrErr_q <= 1'b0;
        end else if (isReady) begin
            if (re) begin
                ra_q    <= ra;
                raVld_q <= raInRange;
            end
            if (ore) begin
                dout_q    <= raVld_q ? rdWord : '0;
                doutVld_q <= raVld_q;
            end
            if ((we && !waInRange) || (re && !raInRange)) begin
                addrErr_q <= 1'b1;
            end
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = doutVld_q;
    assign init_done = isReady;
    assign addr_err  = addrErr_q;

endmodule

// File: tb/tb_sa_ram_rwsp_gen.sv
// Self-checking bench for sa_ram_rwsp_gen: a BYPASS=1 and a BYPASS=0 copy
// share the same stimulus and are compared against one reference model.
module tb_sa_ram_rwsp_gen;

    localparam int DW    = 32;
    localparam int DEPTH = 24;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra = '0;
    logic          re = 1'b0;
    logic          ore = 1'b0;
    logic [AW-1:0] wa = '0;
    logic          we = 1'b0;
    logic [3:0]    wmask = '0;
    logic [DW-1:0] di = '0;
    logic [31:0]   pwrbus = '0;

    logic [DW-1:0] dout1, dout0;
    logic          vld1, vld0, done1, done0, err1, err0;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [DW-1:0] modelMem [DEPTH];
    bit            modelReady;
    int            clrLeft;
    int            raM;
    bit            raValidM;
    logic [DW-1:0] expDout1, expDout0;
    bit            expVld, expErr;

    sa_ram_rwsp_gen #(.DW(DW), .DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout1),
        .dout_vld(vld1), .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(done1), .addr_err(err1), .pwrbus_ram_pd(pwrbus)
    );

    sa_ram_rwsp_gen #(.DW(DW), .DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout0),
        .dout_vld(vld0), .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(done0), .addr_err(err0), .pwrbus_ram_pd(pwrbus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic applyStimulus(input bit rstV, input bit weV, input int waV, input logic [3:0] mk,
                                 input logic [DW-1:0] dv, input bit reV, input int raV, input bit oreV);
        logic [DW-1:0] w;
        @(negedge clk);
        rst = rstV; we = weV; wa = waV[AW-1:0]; wmask = mk; di = dv;
        re = reV; ra = raV[AW-1:0]; ore = oreV; pwrbus = $urandom;
        if (rstV) begin
            modelReady = 0; clrLeft = DEPTH; raM = 0; raValidM = 0;
            expDout1 = '0; expDout0 = '0; expVld = 0; expErr = 0;
        end else if (!modelReady) begin
            modelMem[DEPTH - clrLeft] = '0;
            clrLeft--;
            if (clrLeft == 0) modelReady = 1;
        end else begin
            if (oreV) begin
                if (raValidM) begin
                    w = modelMem[raM];
                    expDout0 = w;
                    if (weV && waV == raM)
                        for (int b = 0; b < 4; b++) if (mk[b]) w[8*b +: 8] = dv[8*b +: 8];
                    expDout1 = w;
                end else begin
                    expDout1 = '0; expDout0 = '0;
                end
                expVld = raValidM;
            end
            if (weV) begin
                if (waV < DEPTH) begin
                    w = modelMem[waV];
                    for (int b = 0; b < 4; b++) if (mk[b]) w[8*b +: 8] = dv[8*b +: 8];
                    modelMem[waV] = w;
                end else begin
                    expErr = 1;
                end
            end
            if (reV) begin
                raM = raV;
                raValidM = (raV < DEPTH);
                if (!raValidM) expErr = 1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("dout_byp1", dout1, expDout1);
        checkOutput("dout_byp0", dout0, expDout0);
        checkOutput("vld_byp1", {31'b0, vld1}, {31'b0, expVld});
        checkOutput("vld_byp0", {31'b0, vld0}, {31'b0, expVld});
        checkOutput("init_done", {30'b0, done1, done0}, {30'b0, modelReady, modelReady});
        checkOutput("addr_err", {30'b0, err1, err0}, {30'b0, expErr, expErr});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'h0, '0, 0, 0, 0);
    endtask

    task automatic writeWord(input int a, input logic [DW-1:0] d, input logic [3:0] mk);
        applyStimulus(0, 1, a, mk, d, 0, 0, 0);
    endtask

    task automatic readWord(input int a);
        applyStimulus(0, 0, 0, 4'h0, '0, 1, a, 0);
        applyStimulus(0, 0, 0, 4'h0, '0, 0, 0, 1);
    endtask

    initial begin
        // Reset for two cycles, then clear while hammering ignored accesses.
        applyStimulus(1, 0, 0, 4'h0, '0, 0, 0, 0);
        applyStimulus(1, 0, 0, 4'h0, '0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, $urandom_range(0, DEPTH - 1), 4'hF, 32'hFFFF_FFFF,
                          1, $urandom_range(0, DEPTH - 1), 1);
            if (i == DEPTH - 2) checkOutput("done_early", {31'b0, done1}, 32'd0);
        end
        checkOutput("done_rise", {31'b0, done1}, 32'd1);

        // Cleared words read back as zero with valid set.
        readWord(0);
        checkOutput("clr_rd0", dout1, 32'h0);
        checkOutput("clr_vld0", {31'b0, vld1}, 32'd1);
        readWord(23);
        checkOutput("clr_rd23", dout1, 32'h0);
        readWord(11);
        checkOutput("clr_rd11", dout0, 32'h0);

        // Byte-masked write merge.
        writeWord(5, 32'hDEAD_BEEF, 4'b1111);
        writeWord(5, 32'h1122_3344, 4'b0101);
        readWord(5);
        checkOutput("merge5", dout1, 32'hDE22_BE44);

        // Write then read same address in the same cycle returns new data.
        applyStimulus(0, 1, 9, 4'hF, 32'hCAFE_F00D, 1, 9, 0);
        applyStimulus(0, 0, 0, 4'h0, '0, 0, 0, 1);
        checkOutput("wr_rd_same", dout0, 32'hCAFE_F00D);

        // Forwarding versus pre-write data.
        writeWord(7, 32'h1234_5678, 4'hF);
        applyStimulus(0, 0, 0, 4'h0, '0, 1, 7, 0);
        applyStimulus(0, 1, 7, 4'b0011, 32'hA5A5_A5A5, 0, 0, 1);
        checkOutput("fwd_byp1", dout1, 32'h1234_A5A5);
        checkOutput("fwd_byp0", dout0, 32'h1234_5678);
        readWord(7);
        checkOutput("fwd_after", dout0, 32'h1234_A5A5);

        // Out-of-range read: zero data, no valid, sticky error.
        readWord(30);
        checkOutput("oor_dout", dout1, 32'h0);
        checkOutput("oor_vld", {31'b0, vld1}, 32'd0);
        checkOutput("oor_err", {31'b0, err1}, 32'd1);
        readWord(3);
        checkOutput("err_sticky", {31'b0, err0}, 32'd1);

        // Reset part-way through the clear restarts the full sequence.
        applyStimulus(1, 0, 0, 4'h0, '0, 0, 0, 0);
        idle(10);
        applyStimulus(1, 0, 0, 4'h0, '0, 0, 0, 0);
        idle(DEPTH - 1);
        checkOutput("reclr_wait", {31'b0, done0}, 32'd0);
        idle(1);
        checkOutput("reclr_done", {31'b0, done0}, 32'd1);

        // Back-to-back reads of the addr*3 pattern.
        for (int a = 0; a < DEPTH; a++) writeWord(a, 32'(a * 3), 4'hF);
        applyStimulus(0, 0, 0, 4'h0, '0, 1, 0, 0);
        for (int a = 1; a <= DEPTH; a++) begin
            applyStimulus(0, 0, 0, 4'h0, '0, a < DEPTH, a, 1);
            checkOutput("b2b_data", dout1, 32'((a - 1) * 3));
            checkOutput("b2b_vld", {31'b0, vld1}, 32'd1);
        end

        // Randomised traffic, including occasional out-of-range and resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 31), 4'($urandom), $urandom,
                          $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
